alarm_fsm_multi: RTL and testbench

Parametrised controller FSM for the alarm clock. It decodes keypad and button input into load, shift and display strobes for the key register, the alarm register bank and the time counter. It generalises the single-alarm controller in three ways: selectable alarm slots, a configurable key-entry timeout, and a digit-counted entry. It sits between the keypad scanner and the key/alarm/counter datapath.

---
 rtl/alarm_fsm_multi.sv | 130 +++++++++++++
 tb/tb_alarm_fsm_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_fsm_multi.sv
// Alarm clock controller FSM: multi-slot alarms, entry timeout and digit-counted entry.
// Optional ALARM_FSM_DIGIT_LIMIT_EN: commit only when entry is full, and ignore digits once full.
module alarm_fsm_multi #(
  parameter int unsigned TIMEOUT_SECS = 10,
  parameter int unsigned NUM_ALARMS   = 2,
  parameter int unsigned DIGITS       = 4,
  localparam int unsigned SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int unsigned CNT_W = $clog2(DIGITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_second,
  input  logic             time_button,
  input  logic             alarm_button,
  input  logic             alarm_next,
  input  logic [3:0]       key,
  output logic             load_new_a,
  output logic             show_a,
  output logic             show_new_time,
  output logic             load_new_c,
  output logic             reset_count,
  output logic             shift,
  output logic [SEL_W-1:0] alarm_sel,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             time_out,
  output logic             entry_full
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [7:0]       TO_V    = 8'(TIMEOUT_SECS);
  localparam logic [CNT_W-1:0] DIG_V   = CNT_W'(DIGITS);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_ALARMS - 1);

  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             is_digit;
  logic             commit_ok;
  logic             shift_ok;

  assign is_digit   = (key <= 4'd9);
  assign time_out   = (timer_q == TO_V);
  assign entry_full = (cnt_q == DIG_V);
  assign digit_cnt  = cnt_q;
  assign alarm_sel  = sel_q;

`ifdef ALARM_FSM_DIGIT_LIMIT_EN
  assign commit_ok = entry_full;
  assign shift_ok  = !entry_full;
`else
  assign commit_ok = 1'b1;
  assign shift_ok  = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (alarm_button)  state_d = SHOW_ALARM;
        else if (is_digit) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!is_digit)     state_d = KEY_ENTRY;
        else if (time_out) state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        // Gated buttons/digits are treated as absent, so a timeout can still abort.
        if (alarm_button && commit_ok)     state_d = SET_ALARM_TIME;
        else if (time_button && commit_ok) state_d = SET_CURRENT_TIME;
        else if (time_out)                 state_d = SHOW_TIME;
        else if (is_digit && shift_ok)     state_d = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    timer_d = '0;
    if (state_q == KEY_WAITED || state_q == KEY_ENTRY) begin
      timer_d = timer_q;
      if (one_second && timer_q != TO_V) timer_d = timer_q + 8'd1;
    end

    cnt_d = cnt_q;
    if (state_q == SHOW_TIME)                        cnt_d = '0;
    else if (state_q == KEY_STORED && cnt_q != DIG_V) cnt_d = cnt_q + 1'b1;

    sel_d = sel_q;
    if (alarm_next && (state_q == SHOW_TIME || state_q == SHOW_ALARM))
      sel_d = (sel_q >= SEL_MAX) ? '0 : sel_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      timer_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign shift         = (state_q == KEY_STORED);
  assign show_a        = (state_q == SHOW_ALARM);
  assign load_new_a    = (state_q == SET_ALARM_TIME);
  assign load_new_c    = (state_q == SET_CURRENT_TIME);
  assign reset_count   = (state_q == SET_CURRENT_TIME);

endmodule

// File: tb/tb_alarm_fsm_multi.sv
// Directed self-checking bench for alarm_fsm_multi with default parameters.
module tb_alarm_fsm_multi;
  logic       clock = 1'b0;
  logic       reset, one_second, time_button, alarm_button, alarm_next;
  logic [3:0] key;
  logic       load_new_a, show_a, show_new_time, load_new_c, reset_count, shift;
  logic [0:0] alarm_sel;
  logic [2:0] digit_cnt;
  logic       time_out, entry_full;

  int checks = 0;
  int failures = 0;

  alarm_fsm_multi #(.TIMEOUT_SECS(10), .NUM_ALARMS(2), .DIGITS(4)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .time_button(time_button),
    .alarm_button(alarm_button), .alarm_next(alarm_next), .key(key),
    .load_new_a(load_new_a), .show_a(show_a), .show_new_time(show_new_time),
    .load_new_c(load_new_c), .reset_count(reset_count), .shift(shift),
    .alarm_sel(alarm_sel), .digit_cnt(digit_cnt), .time_out(time_out), .entry_full(entry_full)
  );

  always #5 clock = ~clock;

  // {load_new_a, show_a, show_new_time, load_new_c, reset_count, shift}
  localparam logic [5:0] S_IDLE  = 6'b000000;
  localparam logic [5:0] S_STORE = 6'b001001;
  localparam logic [5:0] S_ENTRY = 6'b001000;
  localparam logic [5:0] S_ALARM = 6'b010000;
  localparam logic [5:0] S_LDA   = 6'b100000;
  localparam logic [5:0] S_LDC   = 6'b000110;

  function automatic logic [5:0] strb();
    return {load_new_a, show_a, show_new_time, load_new_c, reset_count, shift};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_digit(input logic [3:0] d);
    key = d;
    tick(1);
    key = 4'd10;
    tick(2);
  endtask

  task automatic pulse_second();
    one_second = 1'b1;
    tick(1);
    one_second = 1'b0;
  endtask

  initial begin
    reset = 1'b0; one_second = 1'b0; time_button = 1'b0;
    alarm_button = 1'b0; alarm_next = 1'b0; key = 4'd10;
    #1 reset = 1'b1;
    #2;
    check("reset_strobes", 32'(strb()), 32'(S_IDLE));
    check("reset_status", {29'd0, time_out, entry_full, alarm_sel}, 32'd0);
    check("reset_cnt", 32'(digit_cnt), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("idle_after_reset", 32'(strb()), 32'(S_IDLE));

    // Single digit held two cycles
    key = 4'd3;
    tick(1);
    check("key_stored", 32'(strb()), 32'(S_STORE));
    tick(1);
    check("key_waited_held", 32'(strb()), 32'(S_ENTRY));
    check("cnt_one", 32'(digit_cnt), 32'd1);
    key = 4'd10;
    tick(1);
    check("key_entry", 32'(strb()), 32'(S_ENTRY));

    // Fill to four digits and commit as current time
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd5);
    check("cnt_four", 32'(digit_cnt), 32'd4);
    check("entry_full", 32'(entry_full), 32'd1);
    time_button = 1'b1;
    tick(1);
    check("load_c", 32'(strb()), 32'(S_LDC));
    tick(1);
    check("after_load_c", 32'(strb()), 32'(S_IDLE));
    tick(1);
    check("still_show_time", 32'(strb()), 32'(S_IDLE));
    check("cnt_cleared", 32'(digit_cnt), 32'd0);
    time_button = 1'b0;

    // Partial entry with alarm_button
    press_digit(4'd7); press_digit(4'd8);
    check("cnt_two", 32'(digit_cnt), 32'd2);
    alarm_button = 1'b1;
    tick(1);
`ifdef ALARM_FSM_DIGIT_LIMIT_EN
    check("partial_alarm_ignored", 32'(strb()), 32'(S_ENTRY));
    alarm_button = 1'b0;
    press_digit(4'd0); press_digit(4'd9);
    check("cnt_full", 32'(entry_full), 32'd1);
    key = 4'd5;
    tick(1);
    check("digit_ignored_full", 32'(strb()), 32'(S_ENTRY));
    key = 4'd10;
    alarm_button = 1'b1;
    tick(1);
    check("full_alarm_load", 32'(strb()), 32'(S_LDA));
`else
    check("partial_alarm_load", 32'(strb()), 32'(S_LDA));
`endif
    alarm_button = 1'b0;
    tick(1);
    check("back_show_time", 32'(strb()), 32'(S_IDLE));

    // Alarm slot selection
    alarm_next = 1'b1; tick(1); alarm_next = 1'b0;
    check("sel_one", 32'(alarm_sel), 32'd1);
    alarm_next = 1'b1; tick(1); alarm_next = 1'b0;
    check("sel_wrap", 32'(alarm_sel), 32'd0);
    alarm_next = 1'b1; alarm_button = 1'b1;
    tick(1);
    alarm_next = 1'b0;
    check("show_alarm", 32'(strb()), 32'(S_ALARM));
    check("show_alarm_sel", 32'(alarm_sel), 32'd1);
    alarm_next = 1'b1; tick(1); alarm_next = 1'b0;
    check("sel_in_show_alarm", 32'(alarm_sel), 32'd0);
    alarm_button = 1'b0;
    tick(1);
    check("leave_show_alarm", 32'(strb()), 32'(S_IDLE));
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_digit(4'd4);
    alarm_next = 1'b1; tick(1); alarm_next = 1'b0;
    check("sel_frozen_entry", 32'(alarm_sel), 32'd0);
    check("entry_held", 32'(strb()), 32'(S_ENTRY));
    alarm_button = 1'b1;
    tick(1);
    alarm_button = 1'b0;
    check("load_a", 32'(strb()), 32'(S_LDA));
    check("load_a_sel", 32'(alarm_sel), 32'd0);
    tick(1);
    check("after_load_a", 32'(strb()), 32'(S_IDLE));

    // Entry timeout
    press_digit(4'd6);
    for (int i = 1; i <= 9; i++) begin
      pulse_second();
      check("no_timeout_yet", 32'(time_out), 32'd0);
    end
    pulse_second();
    check("timeout_hi", 32'(time_out), 32'd1);
    check("timeout_still_entry", 32'(strb()), 32'(S_ENTRY));
    tick(1);
    check("timeout_abort", 32'(strb()), 32'(S_IDLE));
    tick(1);

    // Digit at tick 9 restarts the timer
    press_digit(4'd6);
    for (int i = 1; i <= 8; i++) pulse_second();
    one_second = 1'b1; key = 4'd7;
    tick(1);
    one_second = 1'b0; key = 4'd10;
    check("restart_store", 32'(strb()), 32'(S_STORE));
    tick(2);
    for (int i = 1; i <= 9; i++) pulse_second();
    check("restart_no_timeout", 32'(time_out), 32'd0);
    check("restart_entry", 32'(strb()), 32'(S_ENTRY));
    pulse_second();
    check("restart_timeout", 32'(time_out), 32'd1);
    tick(1);
    check("restart_abort", 32'(strb()), 32'(S_IDLE));
    tick(1);

    // Asynchronous reset mid-entry
    alarm_next = 1'b1; tick(1); alarm_next = 1'b0;
    check("sel_before_reset", 32'(alarm_sel), 32'd1);
    key = 4'd2;
    tick(2);
    check("in_key_waited", 32'(strb()), 32'(S_ENTRY));
    reset = 1'b1;
    #2;
    check("async_strobes", 32'(strb()), 32'(S_IDLE));
    check("async_status", {29'd0, time_out, entry_full, alarm_sel}, 32'd0);
    check("async_cnt", 32'(digit_cnt), 32'd0);
    key = 4'd10;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post_reset_idle", 32'(strb()), 32'(S_IDLE));
    key = 4'd4;
    tick(1);
    key = 4'd10;
    check("post_reset_store", 32'(strb()), 32'(S_STORE));
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
